display_arbiter: RTL and testbench

Shares the 4-digit seven-segment display between two BCD digit sources, such as the scrolling pattern decorator and a counter/status source. It grants the display to one source at a time through a request/grant handshake. Each grant has a guaranteed minimum hold time and is followed by round-robin fairness. One blanking cycle is inserted between owners. It sits between the digit producers and the seven-segment multiplexer/decoder, and its registered outputs replace the producers' direct connections.

---
 rtl/display_arbiter_pkg.sv | 33 +++
 rtl/display_arbiter_if.sv | 22 ++
 rtl/display_arbiter_hold_timer.sv | 37 +++
 rtl/display_arbiter.sv | 116 +++++++++++
 tb/tb_display_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/display_arbiter_pkg.sv
// Shared display definitions: character codes, arbiter state encoding and
// the grant decode used by the display arbiter.
package display_arbiter_pkg;

    typedef enum logic [3:0] {
        CHAR_C     = 4'h2,
        CHAR_E     = 4'h5,
        CHAR_BLANK = 4'hF
    } char_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN0  = 2'd1;
    localparam logic [1:0] ST_OWN1  = 2'd2;
    localparam logic [1:0] ST_BLANK = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        OWN0  = ST_OWN0,
        OWN1  = ST_OWN1,
        BLANK = ST_BLANK
    } arb_state_e;

    localparam logic [15:0] BLANK_DIGITS = {4{CHAR_BLANK}};

    function automatic logic [1:0] grant_of(input arb_state_e s);
        case (s)
            OWN0:    return 2'b01;
            OWN1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Bundle of request, source digit and display-side signals of the arbiter.
interface display_arbiter_if;
    logic [1:0]  req;
    logic [15:0] src0_bcd;
    logic [15:0] src1_bcd;
    logic [1:0]  grant;
    logic [3:0]  bcd3;
    logic [3:0]  bcd2;
    logic [3:0]  bcd1;
    logic [3:0]  bcd0;
    logic [1:0]  led;

    modport master (
        output req, src0_bcd, src1_bcd,
        input  grant, bcd3, bcd2, bcd1, bcd0, led
    );

    modport slave (
        input  req, src0_bcd, src1_bcd,
        output grant, bcd3, bcd2, bcd1, bcd0, led
    );
endinterface

// File: rtl/display_arbiter_hold_timer.sv
// Saturating dwell counter: cleared by clr_i, counts while en_i, and flags
// done_o once it has reached CYCLES-1 (it then stays there).
module hold_timer #(
    parameter int unsigned CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);
    localparam int unsigned W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/display_arbiter.sv
// Two-source round-robin owner of the 4-digit display with a minimum hold
// time per grant and one blank cycle between different owners.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 8
) (
    input logic              clk,
    input logic              rst,
    display_arbiter_if.slave bus
);
    arb_state_e  state_q, state_d;
    logic        last_q, last_d;
    logic        target_q, target_d;
    logic        owning;
    logic        hold_done;
    logic [1:0]  grant_q;
    logic [15:0] digits_q;

    assign owning = (state_q == OWN0) || (state_q == OWN1);

    // Counter sits at zero whenever nobody owns, so entry into OWNx starts fresh.
    hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!owning),
        .en_i   (owning),
        .done_o (hold_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            target_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (bus.req == 2'b11) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (bus.req[0]) begin
                    state_d = OWN0;
                end else if (bus.req[1]) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (hold_done) begin
                    if (bus.req[1]) begin
                        state_d  = BLANK;
                        target_d = 1'b1;
                        last_d   = 1'b0;
                    end else if (!bus.req[0]) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end
                end
            end
            OWN1: begin
                if (hold_done) begin
                    if (bus.req[0]) begin
                        state_d  = BLANK;
                        target_d = 1'b0;
                        last_d   = 1'b1;
                    end else if (!bus.req[1]) begin
                        state_d = IDLE;
                        last_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (bus.req[target_q]) begin
                    state_d = target_q ? OWN1 : OWN0;
                end else if (bus.req[~target_q]) begin
                    state_d = target_q ? OWN0 : OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Digits are a one-stage pipeline of the current owner's inputs, so they
    // trail grant by one cycle; grant itself is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q  <= 2'b00;
            digits_q <= BLANK_DIGITS;
        end else begin
            grant_q <= grant_of(state_d);
            case (state_q)
                OWN0:    digits_q <= bus.src0_bcd;
                OWN1:    digits_q <= bus.src1_bcd;
                default: digits_q <= BLANK_DIGITS;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.led   = grant_q;
    assign bus.bcd3  = digits_q[15:12];
    assign bus.bcd2  = digits_q[11:8];
    assign bus.bcd1  = digits_q[7:4];
    assign bus.bcd0  = digits_q[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Randomised scoreboard bench for display_arbiter, run on two instances
// (HOLD_CYCLES=4 and HOLD_CYCLES=1) driven with identical stimulus.
`timescale 1ns/1ps
module tb_display_arbiter;

    typedef struct packed {
        logic [1:0]  grant;
        logic [15:0] digits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_v = 2'b11;
    logic [15:0] s0_v = 16'h2F5F;
    logic [15:0] s1_v = 16'h1234;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: who owns the display, how long it has held it, and
    // whether the one-cycle changeover gap is in progress.
    int hold_len[2] = '{4, 1};
    int m_owner[2];
    int m_held[2];
    bit m_gap[2];
    bit m_last[2];
    bit m_target[2];

    always #5 clk = ~clk;

    display_arbiter_if if4 ();
    display_arbiter_if if1 ();

    assign if4.req      = req_v;
    assign if4.src0_bcd = s0_v;
    assign if4.src1_bcd = s1_v;
    assign if1.req      = req_v;
    assign if1.src0_bcd = s0_v;
    assign if1.src1_bcd = s1_v;

    display_arbiter #(.HOLD_CYCLES(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    display_arbiter #(.HOLD_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i]  = -1;
            m_held[i]   = 0;
            m_gap[i]    = 1'b0;
            m_last[i]   = 1'b1;
            m_target[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input logic [1:0] r, input logic [15:0] a,
                              input logic [15:0] b, output exp_t e);
        int prev;
        int other;
        prev = m_owner[i];
        e.digits = (prev == 0) ? a : (prev == 1) ? b : 16'hFFFF;
        if (m_gap[i]) begin
            m_gap[i] = 1'b0;
            m_held[i] = 0;
            if (r[m_target[i]])       m_owner[i] = m_target[i] ? 1 : 0;
            else if (r[~m_target[i]]) m_owner[i] = m_target[i] ? 0 : 1;
            else                      m_owner[i] = -1;
        end else if (prev < 0) begin
            m_held[i] = 0;
            if (r == 2'b11)   m_owner[i] = m_last[i] ? 0 : 1;
            else if (r[0])    m_owner[i] = 0;
            else if (r[1])    m_owner[i] = 1;
        end else begin
            m_held[i]++;
            if (m_held[i] >= hold_len[i]) begin
                other = 1 - prev;
                if (r[other[0]]) begin
                    m_gap[i]    = 1'b1;
                    m_target[i] = other[0];
                    m_last[i]   = prev[0];
                    m_owner[i]  = -1;
                end else if (!r[prev[0]]) begin
                    m_last[i]  = prev[0];
                    m_owner[i] = -1;
                end
            end
        end
        e.grant = (m_owner[i] == 0) ? 2'b01 : (m_owner[i] == 1) ? 2'b10 : 2'b00;
    endtask

    // Drive one cycle of inputs at a falling edge and queue what must appear
    // after the following rising edge.
    task automatic step_src(input logic [1:0] r, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        req_v = r;
        s0_v  = a;
        s1_v  = b;
        model_step(0, r, a, b, e);
        q0.push_back(e);
        model_step(1, r, a, b, e);
        q1.push_back(e);
        @(negedge clk);
    endtask

    task automatic step(input logic [1:0] r);
        step_src(r, 16'($urandom), 16'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("h4_grant", {14'd0, if4.grant}, {14'd0, e.grant});
                check("h4_led", {14'd0, if4.led}, {14'd0, e.grant});
                check("h4_digits", {if4.bcd3, if4.bcd2, if4.bcd1, if4.bcd0}, e.digits);
                $display("txn h4 grant=%b digits=%h exp_grant=%b exp_digits=%h",
                         if4.grant, {if4.bcd3, if4.bcd2, if4.bcd1, if4.bcd0}, e.grant, e.digits);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("h1_grant", {14'd0, if1.grant}, {14'd0, e.grant});
                check("h1_led", {14'd0, if1.led}, {14'd0, e.grant});
                check("h1_digits", {if1.bcd3, if1.bcd2, if1.bcd1, if1.bcd0}, e.digits);
                $display("txn h1 grant=%b digits=%h exp_grant=%b exp_digits=%h",
                         if1.grant, {if1.bcd3, if1.bcd2, if1.bcd1, if1.bcd0}, e.grant, e.digits);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_h4_grant"}, {14'd0, if4.grant}, 16'h0000);
        check({tag, "_h4_led"}, {14'd0, if4.led}, 16'h0000);
        check({tag, "_h4_digits"}, {if4.bcd3, if4.bcd2, if4.bcd1, if4.bcd0}, 16'hFFFF);
        check({tag, "_h1_grant"}, {14'd0, if1.grant}, 16'h0000);
        check({tag, "_h1_led"}, {14'd0, if1.led}, 16'h0000);
        check({tag, "_h1_digits"}, {if1.bcd3, if1.bcd2, if1.bcd1, if1.bcd0}, 16'hFFFF);
    endtask

    initial begin : stimulus
        logic [1:0] r;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Contended: strict alternation with fixed sources.
        repeat (24) step_src(2'b11, 16'h2F5F, 16'h1234);
        repeat (6) step(2'b00);

        // Single-cycle pulse from source 0.
        step(2'b01);
        repeat (7) step(2'b00);

        // Source 1 arrives after hold_done, then drops during the gap.
        repeat (6) step(2'b01);
        step(2'b11);
        repeat (4) step(2'b01);
        repeat (6) step(2'b00);

        // Random requests that tend to persist for several cycles.
        r = 2'b00;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) r = 2'($urandom_range(0, 3));
            step(r);
        end

        // Asynchronous reset landing in the middle of an OWN1 grant.
        repeat (6) step(2'b00);
        repeat (2) step(2'b10);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (12) step(2'b11);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 16'(q0.size() + q1.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
